// File: rtl/scope_uart_pkg.sv
// ---------------------------------------------------------------------------
// scope_uart_pkg
// Shared definitions for the host serial link: the UART state encoding used
// by both the receive and transmit state machines, the 8N1 frame length and
// the number of bytes that make up one host command.
// No ports.
// ---------------------------------------------------------------------------
package scope_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  localparam int CMD_BYTES = 3;

endpackage

// File: rtl/host_cmd_link_if.sv
// ---------------------------------------------------------------------------
// host_cmd_link_if
// Parallel side of the host link as seen by the command processor.
//   cmd         [23:0] assembled command, first byte received in [23:16]
//   cmd_rdy            cmd holds a complete, unconsumed command
//   clr_cmd_rdy        one-cycle pulse: command consumed
//   resp_data   [7:0]  byte to send to the host
//   send_resp          one-cycle pulse: start sending resp_data
//   resp_sent          high once a response frame has finished
// master = command processor, slave = host_cmd_link.
// ---------------------------------------------------------------------------
interface host_cmd_link_if;

  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    input  cmd,
    input  cmd_rdy,
    input  resp_sent,
    output clr_cmd_rdy,
    output resp_data,
    output send_resp
  );

  modport slave (
    output cmd,
    output cmd_rdy,
    output resp_sent,
    input  clr_cmd_rdy,
    input  resp_data,
    input  send_resp
  );

endinterface

// File: rtl/host_uart_tx.sv
// ---------------------------------------------------------------------------
// host_uart_tx
// 8N1 transmitter for response and dump bytes going back to the host.
//   clk, rst_n   system clock, asynchronous active-low reset
//   resp_data    byte latched when send_resp is seen while idle
//   send_resp    one-cycle start pulse; ignored while a frame is in flight
//   tx           serial line, idles high
//   resp_sent    high once a frame's stop bit has finished, low from the
//                next accepted send_resp
// ---------------------------------------------------------------------------
module host_uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] resp_data,
  input  logic       send_resp,
  output logic       tx,
  output logic       resp_sent
);

  import scope_uart_pkg::*;

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BIT_LAST = TW'(BAUD_DIV - 1);

  uart_state_t   state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          sent_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      resp_sent <= 1'b1;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      tx        <= tx_nxt;
      resp_sent <= sent_nxt;
    end
  end

  // tx is registered, so each bit value is loaded on the edge that ends the
  // previous bit; the timer reloads to BAUD_DIV-1 so every bit is exactly
  // BAUD_DIV clocks and resp_sent rises 10*BAUD_DIV clocks after acceptance.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    tx_nxt      = tx;
    sent_nxt    = resp_sent;
    case (state)
      IDLE: begin
        if (send_resp) begin
          state_nxt = START;
          shift_nxt = resp_data;
          timer_nxt = BIT_LAST;
          tx_nxt    = 1'b0;
          sent_nxt  = 1'b0;
        end
      end
      START: begin
        if (timer == '0) begin
          state_nxt   = DATA;
          tx_nxt      = shift[0];
          shift_nxt   = {1'b0, shift[7:1]};
          bit_cnt_nxt = '0;
          timer_nxt   = BIT_LAST;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_nxt = BIT_LAST;
          if (bit_cnt == 4'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            tx_nxt      = shift[0];
            shift_nxt   = {1'b0, shift[7:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      STOP: begin
        if (timer == '0) begin
          state_nxt = IDLE;
          sent_nxt  = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/host_cmd_link.sv
// ---------------------------------------------------------------------------
// host_cmd_link
// Host-side serial front end. Receives 8N1 bytes on RX, assembles every
// three into a 24-bit command with a cmd_rdy/clr_cmd_rdy handshake, and
// sends single response bytes on TX through host_uart_tx.
//   clk, rst_n   system clock, asynchronous active-low reset
//   RX           serial input from host, asynchronous, idles high
//   TX           serial output to host, idles high
//   bus          host_cmd_link_if.slave: cmd, cmd_rdy, clr_cmd_rdy,
//                resp_data, send_resp, resp_sent
// Parameters: BAUD_DIV clocks per bit (>= 8), GAP_FRAMES idle frame-times
// after which a partially received command is thrown away.
// ---------------------------------------------------------------------------
module host_cmd_link #(
  parameter int BAUD_DIV   = 434,
  parameter int GAP_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  output logic TX,
  host_cmd_link_if.slave bus
);

  import scope_uart_pkg::*;

  localparam int TW        = $clog2(BAUD_DIV);
  localparam int GAP_TICKS = GAP_FRAMES * FRAME_BITS * BAUD_DIV;
  localparam int GW        = $clog2(GAP_TICKS + 1);

  localparam logic [TW-1:0] HALF_BIT  = TW'(BAUD_DIV / 2);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BAUD_DIV - 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_TICKS);
  localparam logic [1:0]    LAST_IDX  = 2'(CMD_BYTES - 1);

  logic rx_s1, rx_s2, rx_d;

  uart_state_t   rx_state, rx_state_nxt;
  logic [TW-1:0] rx_timer, rx_timer_nxt;
  logic [3:0]    rx_bit_cnt, rx_bit_cnt_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic          start_entry;
  logic          byte_valid;
  logic          frame_err;

  logic [23:0]   cmd_q;
  logic          cmd_rdy_q;
  logic [1:0]    byte_idx;
  logic [GW-1:0] gap_cnt;
  logic          gap_run;
  logic          gap_expired;
  logic          resp_sent_w;

  // Two-flop synchroniser plus one more flop so a falling edge can be seen
  // on the clean signal. Resetting all three high means a line that is
  // already low at reset release is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= IDLE;
      rx_timer   <= '0;
      rx_bit_cnt <= '0;
      rx_shift   <= '0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_timer   <= rx_timer_nxt;
      rx_bit_cnt <= rx_bit_cnt_nxt;
      rx_shift   <= rx_shift_nxt;
    end
  end

  // The half-bit load on the start edge puts every later sample near the
  // middle of its bit. A start bit that is high again at mid-bit is a glitch.
  always_comb begin
    rx_state_nxt   = rx_state;
    rx_timer_nxt   = rx_timer;
    rx_bit_cnt_nxt = rx_bit_cnt;
    rx_shift_nxt   = rx_shift;
    start_entry    = 1'b0;
    byte_valid     = 1'b0;
    frame_err      = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_d && !rx_s2) begin
          rx_state_nxt = START;
          rx_timer_nxt = HALF_BIT;
          start_entry  = 1'b1;
        end
      end
      START: begin
        if (rx_timer == '0) begin
          rx_state_nxt   = rx_s2 ? IDLE : DATA;
          rx_timer_nxt   = BIT_LAST;
          rx_bit_cnt_nxt = '0;
        end else begin
          rx_timer_nxt = rx_timer - 1'b1;
        end
      end
      DATA: begin
        if (rx_timer == '0) begin
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_timer_nxt = BIT_LAST;
          if (rx_bit_cnt == 4'd7) begin
            rx_state_nxt = STOP;
          end else begin
            rx_bit_cnt_nxt = rx_bit_cnt + 1'b1;
          end
        end else begin
          rx_timer_nxt = rx_timer - 1'b1;
        end
      end
      STOP: begin
        if (rx_timer == '0) begin
          rx_state_nxt = IDLE;
          byte_valid   = rx_s2;
          frame_err    = !rx_s2;
        end else begin
          rx_timer_nxt = rx_timer - 1'b1;
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  // The gap timer only matters while a command is half built and the line
  // is quiet; a new start bit wins over an expiry in the same cycle.
  assign gap_run     = (rx_state == IDLE) && (byte_idx != '0) && !start_entry;
  assign gap_expired = gap_run && (gap_cnt == GAP_LIMIT);

  // cmd only shifts on a completed byte, and every byte begins with a start
  // entry that has already dropped cmd_rdy, so cmd never moves while cmd_rdy
  // is high. Completion is tested before the clear so set wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
    end else begin
      if (byte_valid) begin
        cmd_q <= {cmd_q[15:0], rx_shift};
      end

      if (byte_valid && (byte_idx == LAST_IDX)) begin
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy || start_entry) begin
        cmd_rdy_q <= 1'b0;
      end

      if (byte_valid) begin
        byte_idx <= (byte_idx == LAST_IDX) ? 2'd0 : byte_idx + 1'b1;
      end else if (frame_err || gap_expired) begin
        byte_idx <= '0;
      end

      if (!gap_run || gap_expired) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.resp_sent = resp_sent_w;

  host_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .resp_data (bus.resp_data),
    .send_resp (bus.send_resp),
    .tx        (TX),
    .resp_sent (resp_sent_w)
  );

endmodule

// File: tb/tb_host_cmd_link.sv
// ---------------------------------------------------------------------------
// tb_host_cmd_link
// Directed bench for host_cmd_link at BAUD_DIV=16, GAP_FRAMES=4. A frame-level
// model of the transmitter and a byte-level model of command assembly give
// the expected outputs; a negedge process compares them every cycle, and
// literal values pin the model at key points.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_host_cmd_link;

  localparam int B         = 16;
  localparam int GAPF      = 4;
  localparam int GAP_LIMIT = GAPF * 10 * B;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic tx;

  host_cmd_link_if bus();

  host_cmd_link #(
    .BAUD_DIV   (B),
    .GAP_FRAMES (GAPF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int unsigned cyc         = 0;
  logic        m_tx_busy   = 1'b0;
  logic        m_resp_sent = 1'b1;
  int unsigned m_tx_t0     = 0;
  logic [7:0]  m_tx_byte   = 8'h00;

  int          m_idx       = 0;
  logic [23:0] m_acc       = 24'h0;
  logic [23:0] m_cmd_exp   = 24'h0;
  int          m_rdy_state = 0;   // 0 must be low, 1 either, 2 must be high
  int unsigned m_last_end  = 0;
  bit          compare_en  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Transmitter model: a frame accepted on an edge occupies the next
  // 10*B cycles; outside a frame the line idles high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_tx_busy   <= 1'b0;
      m_resp_sent <= 1'b1;
    end else if (m_tx_busy) begin
      if (cyc - m_tx_t0 == 10 * B) begin
        m_tx_busy   <= 1'b0;
        m_resp_sent <= 1'b1;
      end
    end else if (bus.send_resp) begin
      m_tx_busy   <= 1'b1;
      m_tx_t0     <= cyc;
      m_tx_byte   <= bus.resp_data;
      m_resp_sent <= 1'b0;
    end
  end

  function automatic logic exp_tx();
    int k;
    int idx;
    if (!m_tx_busy) return 1'b1;
    k   = int'(cyc - m_tx_t0);
    idx = (k - 1) / B;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_tx_byte[idx-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && compare_en) begin
      checkOutput("tx_line", tx, exp_tx());
      checkOutput("resp_sent", bus.resp_sent, m_resp_sent);
      if (m_rdy_state == 2) checkOutput("cmd_rdy_high", bus.cmd_rdy, 1);
      else if (m_rdy_state == 0) checkOutput("cmd_rdy_low", bus.cmd_rdy, 0);
      if (bus.cmd_rdy) checkOutput("cmd_value", bus.cmd, m_cmd_exp);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rx_byte(input logic [7:0] data, input logic stop_bit);
    bit completes;
    if (m_idx != 0 && int'(cyc - m_last_end) > GAP_LIMIT - B / 2) m_idx = 0;
    if (m_rdy_state != 0) m_rdy_state = 1;
    rx = 1'b0;
    tick(B);
    if (m_rdy_state == 1) m_rdy_state = 0;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(B);
    end
    completes = stop_bit && (m_idx == 2);
    if (completes) begin
      m_cmd_exp   = {m_acc[15:0], data};
      m_rdy_state = 1;
    end
    rx = stop_bit;
    tick(B);
    if (stop_bit) begin
      m_acc = {m_acc[15:0], data};
      m_idx = completes ? 0 : m_idx + 1;
    end else begin
      m_idx = 0;
    end
    if (completes) begin
      m_rdy_state = 2;
      checkOutput("cmd_rdy_after_stop", bus.cmd_rdy, 1);
    end
    if (!stop_bit) begin
      rx = 1'b1;
      tick(2 * B);
    end
    m_last_end = cyc;
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    m_rdy_state     = 1;
    tick(1);
    bus.clr_cmd_rdy = 1'b0;
    m_rdy_state     = 0;
    checkOutput("clr_cmd_rdy", bus.cmd_rdy, 0);
  endtask

  task automatic wait_resp_sent();
    int n = 0;
    while (!bus.resp_sent && n < 12 * B) begin
      tick(1);
      n++;
    end
    checkOutput("resp_sent_timeout", bus.resp_sent, 1);
  endtask

  task automatic applyStimulus();
    logic tx_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // full command and handshake
    send_rx_byte(8'h05, 1'b1);
    send_rx_byte(8'hA3, 1'b1);
    send_rx_byte(8'h7F, 1'b1);
    checkOutput("full_cmd", bus.cmd, 24'h05A37F);
    tick(3);
    pulse_clr();
    checkOutput("cmd_after_clr", bus.cmd, 24'h05A37F);

    // TX frame 0xA5 with an ignored mid-frame request, then back-to-back
    bus.resp_data = 8'hA5;
    bus.send_resp = 1'b1;
    tick(1);
    bus.send_resp = 1'b0;
    checkOutput("tx_start_low", tx, 0);
    for (int p = 0; p <= 10 * B; p++) begin
      if (p % B == B / 2) checkOutput($sformatf("tx_bit%0d", p / B), tx, tx_bits[p/B]);
      if (p == 3 * B + 2) begin
        bus.resp_data = 8'h00;
        bus.send_resp = 1'b1;
      end
      if (p == 3 * B + 3) bus.send_resp = 1'b0;
      if (p == 10 * B - 1) checkOutput("resp_sent_low_159", bus.resp_sent, 0);
      if (p == 10 * B) checkOutput("resp_sent_at_160", bus.resp_sent, 1);
      if (p < 10 * B) tick(1);
    end
    bus.resp_data = 8'h3C;
    bus.send_resp = 1'b1;
    tick(1);
    bus.send_resp = 1'b0;
    checkOutput("b2b_start_low", tx, 0);
    wait_resp_sent();
    tick(4);

    // framing error discards the partial command
    send_rx_byte(8'h12, 1'b1);
    send_rx_byte(8'h34, 1'b0);
    send_rx_byte(8'h56, 1'b1);
    send_rx_byte(8'h78, 1'b1);
    send_rx_byte(8'h9A, 1'b1);
    checkOutput("framing_cmd", bus.cmd, 24'h56789A);
    pulse_clr();

    // gap timeout discards the partial command
    send_rx_byte(8'h11, 1'b1);
    send_rx_byte(8'h22, 1'b1);
    rx = 1'b1;
    tick(641);
    send_rx_byte(8'hAA, 1'b1);
    send_rx_byte(8'hBB, 1'b1);
    send_rx_byte(8'hCC, 1'b1);
    checkOutput("gap_cmd", bus.cmd, 24'hAABBCC);
    pulse_clr();

    // glitch, then full duplex
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * B);
    fork
      begin
        bus.resp_data = 8'h55;
        bus.send_resp = 1'b1;
        tick(1);
        bus.send_resp = 1'b0;
      end
      begin
        send_rx_byte(8'h01, 1'b1);
        send_rx_byte(8'h02, 1'b1);
        send_rx_byte(8'h03, 1'b1);
      end
    join
    checkOutput("duplex_cmd", bus.cmd, 24'h010203);
    wait_resp_sent();
    pulse_clr();

    // reset in the middle of a TX frame with a command pending
    send_rx_byte(8'hDE, 1'b1);
    send_rx_byte(8'hAD, 1'b1);
    send_rx_byte(8'h01, 1'b1);
    bus.resp_data = 8'h0F;
    bus.send_resp = 1'b1;
    tick(1);
    bus.send_resp = 1'b0;
    tick(5 * B);
    checkOutput("pre_reset_tx_low", tx, 0);
    #2;
    rst_n       = 1'b0;
    m_rdy_state = 0;
    m_idx       = 0;
    #1;
    checkOutput("reset_mid_tx", tx, 1);
    checkOutput("reset_mid_resp_sent", bus.resp_sent, 1);
    checkOutput("reset_mid_cmd_rdy", bus.cmd_rdy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    send_rx_byte(8'h0A, 1'b1);
    send_rx_byte(8'h0B, 1'b1);
    send_rx_byte(8'h0C, 1'b1);
    checkOutput("post_reset_cmd", bus.cmd, 24'h0A0B0C);
    pulse_clr();
    tick(5);
  endtask

  initial begin
    rx              = 1'b1;
    rst_n           = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp_data   = 8'h00;
    tick(3);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_resp_sent", bus.resp_sent, 1);
    checkOutput("reset_cmd_rdy", bus.cmd_rdy, 0);
    checkOutput("reset_cmd", bus.cmd, 24'h0);
    rst_n      = 1'b1;
    compare_en = 1'b1;
    tick(5);
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_cmd_link.md
# host_cmd_link

Host-side serial front end of the scope's digital core. It receives 8N1 UART bytes from the host, assembles each group of three into the 24-bit command consumed by the command processor, and signals it with a `cmd_rdy`/`clr_cmd_rdy` handshake. It also serialises single response and dump bytes back to the host, reporting completion on `resp_sent`. It sits between the board RX/TX pins and the command module.

## Interface
- `BAUD_DIV`, default 434: clocks per bit, so 50 MHz gives 115200 baud. Minimum 8.
- `GAP_FRAMES`, default 4: idle frame-times after which a partial command is discarded.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `RX`  in  1  serial in from host; asynchronous, idles high
- `TX`  out  1  serial out to host; idles high
- `cmd`  out  24  assembled command; first byte received is `[23:16]`
- `cmd_rdy`  out  1  `cmd` holds a complete, unconsumed command
- `clr_cmd_rdy`  in  1  one-cycle pulse: command consumed
- `resp_data`  in  8  byte to transmit
- `send_resp`  in  1  one-cycle pulse: start transmitting `resp_data`
- `resp_sent`  out  1  level; high once a frame finishes, low from the next `send_resp`

## Operation
- **Reset values:**
  - `TX`, `resp_sent` = 1.
  - `cmd`, `cmd_rdy` = 0.
  - `byte_idx` = 0, gap counter = 0.
  - RX synchroniser = 1 (2 flops), both FSMs IDLE.
- **RX FSM (IDLE → START → DATA → STOP → IDLE):**
  - IDLE: a falling edge on the synchronised RX enters START and loads the bit timer with `BAUD_DIV/2`.
  - START: at timer expiry, sample. If the line is high, treat it as a glitch and return to IDLE. If low, enter DATA.
  - DATA: sample 8 bits LSB-first, each after `BAUD_DIV` clocks.
  - STOP: sample once more. 1 means the byte is valid. 0 means a framing error: discard the byte and clear `byte_idx`.
- **Assembly:**
  - On a valid byte, `cmd <= {cmd[15:0], byte}` and `byte_idx` increments.
  - When the third byte lands, `byte_idx` returns to 0 and `cmd_rdy` rises on the same edge as the final shift.
- **Handshake:**
  - `clr_cmd_rdy` clears `cmd_rdy`.
  - A START entry (new frame) also clears `cmd_rdy`.
  - `cmd` is stable while `cmd_rdy` = 1.
  - If `clr_cmd_rdy` coincides with command completion, set wins.
- **Resync:**
  - The gap counter runs while RX is IDLE and `byte_idx` ≠ 0.
  - When it reaches `GAP_FRAMES*10*BAUD_DIV`, `byte_idx` returns to 0.
  - Any START entry clears the gap counter.
- **TX FSM (IDLE → START → DATA → STOP → IDLE):**
  - `send_resp` in IDLE latches `resp_data` and clears `resp_sent`.
  - The frame is start(0), 8 data bits LSB-first, then stop(1), each bit `BAUD_DIV` clocks.
  - At the end of the stop bit, `resp_sent` = 1 and the FSM returns to IDLE.
  - `send_resp` while not IDLE is ignored, and the latched byte is unaffected.
- RX and TX are independent: full duplex.

## Timing
- **TX:** `TX` goes low the cycle after `send_resp`. `resp_sent` rises exactly `10*BAUD_DIV` cycles after the `send_resp` edge. Back-to-back frames are possible: `send_resp` on the cycle `resp_sent` rises starts the next frame with no gap.
- **RX sampling:** data bit n is sampled `BAUD_DIV/2 + (n+1)*BAUD_DIV` cycles (±1) after the synchronised falling edge, plus 2 cycles of synchroniser latency.
- **RX completion:** `cmd_rdy` rises 1 cycle after the stop-bit sample of byte 3.
- **Reset mid-operation:** reset mid-frame returns both FSMs to IDLE immediately and `TX` = 1. A frame already on RX when reset releases is picked up at its next falling edge; misalignment is recovered by the framing-error rule and gap timeout.
- **Widths:**
  - Bit timers are `$clog2(BAUD_DIV)` bits and count down.
  - Bit counters are 4 bits.
  - The gap counter is `$clog2(GAP_FRAMES*10*BAUD_DIV+1)` bits.

## Structure
- Package `scope_uart_pkg`:
  - `typedef enum` `uart_state_t` {IDLE, START, DATA, STOP}, shared by RX and TX.
  - `FRAME_BITS = 10`.
  - `CMD_BYTES = 3`.
- Sub-module `host_uart_tx`: TX FSM, bit timer, shift register, `resp_sent`.
- The top level holds RX, assembly, gap timer and handshake.

## Test plan
- **Full command:** `BAUD_DIV=16`; send bytes 0x05, 0xA3, 0x7F → `cmd`=0x05A37F with `cmd_rdy`=1 one cycle after the third stop sample. Then `clr_cmd_rdy` → `cmd_rdy`=0 and `cmd` unchanged.
- **TX frame:** `send_resp` with `resp_data`=0xA5 → `TX` bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles. `resp_sent` is low for the frame and high at cycle 160. A second `send_resp` mid-frame with 0x00 has no effect.
- **Framing error:** send 0x12, then 0x34 with stop bit 0, then 0x56, 0x78, 0x9A → only 0x56789A is reported.
- **Gap timeout:** `GAP_FRAMES`=4; send 0x11, 0x22, idle 641 cycles, then send 0xAA, 0xBB, 0xCC → `cmd`=0xAABBCC.
- **Glitch and full duplex:** a 4-cycle low pulse on RX produces no byte. Transmitting 0x55 while receiving 0x010203 → both complete correctly.
- **Reset mid-frame:** assert `rst_n`=0 mid-TX → `TX`=1, `resp_sent`=1, `cmd_rdy`=0 immediately.
